// File: rtl/pc_ras.sv
// pc_ras: next-PC generator with a circular return-address stack.
//
// All state changes on the falling edge of clk. rst is asynchronous and
// active-low. Next-PC sources, chosen by branchCtl:
//   000 SEQ     pc + INC (held while halt=1)
//   001 BR_ABS  nextAdrx
//   010 BR_REL  pc + offset (offset is two's complement, full width)
//   011 JR      rfRdData0
//   100 CALL    push pc + INC, pc <= nextAdrx
//   101 RET     pop top of stack into pc (empty stack: pc + INC)
//   11x         reserved, behaves as SEQ
// Redirects (001..101) execute even while halt=1.
//
// Ports:
//   clk, rst                      clock (negedge active), async active-low reset
//   halt                          hold pc unless a redirect is requested
//   branchCtl[2:0]                next-pc select
//   nextAdrx, offset, rfRdData0   address operands, ADDR_W bits
//   pc                            current program count
//   rasCount                      valid stack entries (0..RAS_DEPTH)
//   rasOverflow, rasUnderflow     sticky push-when-full / pop-when-empty flags
//
// Optional feature, macro PC_EXC_EN: adds input exc, output epc and parameter
// EXC_VECTOR. exc=1 at a falling edge overrides branchCtl and halt: it saves
// pc into epc, loads EXC_VECTOR and leaves the stack untouched.

module pc_ras #(
  parameter int unsigned       ADDR_W     = 9,
  parameter int unsigned       INC        = 4,
  parameter int unsigned       RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
`ifdef PC_EXC_EN
  ,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(9'h1F0)
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           halt,
  input  logic [2:0]                     branchCtl,
  input  logic [ADDR_W-1:0]              nextAdrx,
  input  logic [ADDR_W-1:0]              offset,
  input  logic [ADDR_W-1:0]              rfRdData0,
`ifdef PC_EXC_EN
  input  logic                           exc,
  output logic [ADDR_W-1:0]              epc,
`endif
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]     rasCount,
  output logic                           rasOverflow,
  output logic                           rasUnderflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEQ    = 3'b000,
    BR_ABS = 3'b001,
    BR_REL = 3'b010,
    JR     = 3'b011,
    CALL   = 3'b100,
    RET    = 3'b101,
    RSV6   = 3'b110,
    RSV7   = 3'b111
  } brCtl_e;

  brCtl_e              ctl;
  logic [ADDR_W-1:0]   rasMem [RAS_DEPTH];
  logic [PW-1:0]       rasPtr;
  logic [PW-1:0]       pushSlot;
  logic [ADDR_W-1:0]   pcInc;
  logic [ADDR_W-1:0]   pcNext;
  logic                doPush;
  logic                doPop;
  logic                setOvf;
  logic                setUnd;

  assign ctl      = brCtl_e'(branchCtl);
  assign pcInc    = pc + ADDR_W'(INC);
  assign pushSlot = rasPtr + 1'b1;

  always_comb begin
    pcNext = pc;
    doPush = 1'b0;
    doPop  = 1'b0;
    setOvf = 1'b0;
    setUnd = 1'b0;
    case (ctl)
      BR_ABS: pcNext = nextAdrx;
      BR_REL: pcNext = pc + offset;
      JR:     pcNext = rfRdData0;
      CALL: begin
        pcNext = nextAdrx;
        doPush = 1'b1;
        setOvf = (rasCount == FULL);
      end
      RET: begin
        // RET is a redirect, so an empty-stack RET advances even under halt.
        if (rasCount == '0) begin
          pcNext = pcInc;
          setUnd = 1'b1;
        end else begin
          pcNext = rasMem[rasPtr];
          doPop  = 1'b1;
        end
      end
      SEQ, RSV6, RSV7: begin
        if (!halt) pcNext = pcInc;
      end
    endcase
`ifdef PC_EXC_EN
    if (exc) begin
      pcNext = EXC_VECTOR;
      doPush = 1'b0;
      doPop  = 1'b0;
      setOvf = 1'b0;
      setUnd = 1'b0;
    end
`endif
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_ADDR;
      rasPtr       <= '0;
      rasCount     <= '0;
      rasOverflow  <= 1'b0;
      rasUnderflow <= 1'b0;
`ifdef PC_EXC_EN
      epc          <= '0;
`endif
    end else begin
      pc <= pcNext;
      // A push on a full stack still advances the pointer, so the oldest
      // entry is the one overwritten; the count saturates.
      if (doPush) begin
        rasPtr <= pushSlot;
        if (rasCount != FULL) rasCount <= rasCount + 1'b1;
      end else if (doPop) begin
        rasPtr   <= rasPtr - 1'b1;
        rasCount <= rasCount - 1'b1;
      end
      if (setOvf) rasOverflow  <= 1'b1;
      if (setUnd) rasUnderflow <= 1'b1;
`ifdef PC_EXC_EN
      if (exc) epc <= pc;
`endif
    end
  end

  // Stack contents need no reset; validity is tracked by rasCount.
  always_ff @(negedge clk) begin
    if (doPush) rasMem[pushSlot] <= pcInc;
  end

endmodule

// File: tb/tb_pc_ras.sv
`timescale 1ns/100ps
module tb_pc_ras;
  localparam int AW = 9;

  logic          clk = 1'b1;
  logic          rst = 1'b0;
  logic          halt = 1'b0;
  logic [2:0]    branchCtl = 3'd0;
  logic [AW-1:0] nextAdrx = '0;
  logic [AW-1:0] offset = '0;
  logic [AW-1:0] rfRdData0 = '0;
`ifdef PC_EXC_EN
  logic          exc = 1'b0;
  logic [AW-1:0] epc;
`endif
  logic [AW-1:0] pc;
  logic [2:0]    rasCount;
  logic          rasOverflow;
  logic          rasUnderflow;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  // Behavioural model: a queue of return addresses, newest at the back.
  logic [AW-1:0] mPc;
  logic [AW-1:0] mStack[$];
  bit            mOvf;
  bit            mUnd;
  logic [AW-1:0] mEpc;

  pc_ras #(
    .ADDR_W(AW),
    .INC(4),
    .RAS_DEPTH(4),
    .RESET_ADDR(9'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .halt(halt),
    .branchCtl(branchCtl),
    .nextAdrx(nextAdrx),
    .offset(offset),
    .rfRdData0(rfRdData0),
`ifdef PC_EXC_EN
    .exc(exc),
    .epc(epc),
`endif
    .pc(pc),
    .rasCount(rasCount),
    .rasOverflow(rasOverflow),
    .rasUnderflow(rasUnderflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic modelReset();
    mPc = 9'h000;
    mStack.delete();
    mOvf = 0;
    mUnd = 0;
    mEpc = 9'h000;
  endtask

  task automatic modelStep(input logic [2:0] c, input logic h, input logic [AW-1:0] na,
                           input logic [AW-1:0] off, input logic [AW-1:0] rf, input logic x);
    logic [AW-1:0] ra;
    if (x) begin
      mEpc = mPc;
      mPc  = 9'h1F0;
      return;
    end
    case (c)
      3'd1: mPc = na;
      3'd2: mPc = mPc + off;
      3'd3: mPc = rf;
      3'd4: begin
        ra = mPc + 9'd4;
        mStack.push_back(ra);
        if (mStack.size() > 4) begin
          void'(mStack.pop_front());
          mOvf = 1;
        end
        mPc = na;
      end
      3'd5: begin
        if (mStack.size() == 0) begin
          mPc = mPc + 9'd4;
          mUnd = 1;
        end else begin
          mPc = mStack.pop_back();
        end
      end
      default: if (!h) mPc = mPc + 9'd4;
    endcase
  endtask

  // Every rising edge lies midway between active (falling) edges.
  always @(posedge clk) begin
    if (started) begin
      chk("pc", {23'd0, pc}, {23'd0, mPc});
      chk("rasCount", {29'd0, rasCount}, mStack.size());
      chk("rasOverflow", {31'd0, rasOverflow}, {31'd0, mOvf});
      chk("rasUnderflow", {31'd0, rasUnderflow}, {31'd0, mUnd});
`ifdef PC_EXC_EN
      chk("epc", {23'd0, epc}, {23'd0, mEpc});
`endif
    end
  end

  // Called between edges; returns 2 ns after the following rising edge.
  task automatic step(input logic [2:0] c, input logic h, input logic [AW-1:0] na,
                      input logic [AW-1:0] off, input logic [AW-1:0] rf, input logic x);
    branchCtl = c;
    halt      = h;
    nextAdrx  = na;
    offset    = off;
    rfRdData0 = rf;
`ifdef PC_EXC_EN
    exc       = x;
`endif
    @(negedge clk);
    if (rst) modelStep(c, h, na, off, rf, x);
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    #1 rst = 1'b0;
    modelReset();
    #1;
    chk("async_rst_pc", {23'd0, pc}, 32'h000);
    chk("async_rst_cnt", {29'd0, rasCount}, 32'd0);
    chk("async_rst_flags", {30'd0, rasOverflow, rasUnderflow}, 32'd0);
    #1 rst = 1'b1;
  endtask

  task automatic expectPc(input string n, input logic [AW-1:0] e);
    chk(n, {23'd0, pc}, {23'd0, e});
    chk({n, "_model"}, {23'd0, mPc}, {23'd0, e});
  endtask

  initial begin
    logic [2:0] c;
    logic       h;
    logic       x;
    logic [2:0] cntBefore;

    modelReset();
    #3;
    chk("reset_pc", {23'd0, pc}, 32'h000);
    chk("reset_cnt", {29'd0, rasCount}, 32'd0);
    chk("reset_flags", {30'd0, rasOverflow, rasUnderflow}, 32'd0);
    rst = 1'b1;
    started = 1;

    step(3'd0, 0, '0, '0, '0, 0); expectPc("seq1", 9'h004);
    step(3'd0, 0, '0, '0, '0, 0); expectPc("seq2", 9'h008);
    step(3'd0, 0, '0, '0, '0, 0); expectPc("seq3", 9'h00C);
    doReset();

    step(3'd1, 0, 9'h010, '0, '0, 0);     expectPc("abs_setup", 9'h010);
    step(3'd1, 0, 9'h080, '0, '0, 0);     expectPc("br_abs", 9'h080);
    step(3'd2, 0, '0, 9'h1F8, '0, 0);     expectPc("br_rel_neg", 9'h078);
    step(3'd3, 0, '0, '0, 9'h100, 0);     expectPc("jr", 9'h100);
    step(3'd6, 0, 9'h055, '0, '0, 0);     expectPc("rsv6_seq", 9'h104);

    step(3'd1, 0, 9'h020, '0, '0, 0);
    step(3'd4, 0, 9'h100, '0, '0, 0);     expectPc("call1", 9'h100);
    step(3'd4, 0, 9'h200, '0, '0, 0);     expectPc("call2", 9'h000);
    chk("call2_cnt", {29'd0, rasCount}, 32'd2);
    step(3'd5, 0, '0, '0, '0, 0);         expectPc("ret1", 9'h104);
    chk("ret1_cnt", {29'd0, rasCount}, 32'd1);
    step(3'd5, 0, '0, '0, '0, 0);         expectPc("ret2", 9'h024);
    chk("ret2_cnt", {29'd0, rasCount}, 32'd0);

    doReset();
    step(3'd4, 0, 9'h040, '0, '0, 0);
    step(3'd4, 0, 9'h080, '0, '0, 0);
    step(3'd4, 0, 9'h0C0, '0, '0, 0);
    step(3'd4, 0, 9'h100, '0, '0, 0);
    chk("full_no_ovf", {31'd0, rasOverflow}, 32'd0);
    step(3'd4, 0, 9'h140, '0, '0, 0);
    chk("ovf_flag", {31'd0, rasOverflow}, 32'd1);
    chk("ovf_cnt", {29'd0, rasCount}, 32'd4);
    step(3'd5, 0, '0, '0, '0, 0);         expectPc("oret1", 9'h104);
    step(3'd5, 0, '0, '0, '0, 0);         expectPc("oret2", 9'h0C4);
    step(3'd5, 0, '0, '0, '0, 0);         expectPc("oret3", 9'h084);
    step(3'd5, 0, '0, '0, '0, 0);         expectPc("oret4", 9'h044);
    chk("pre_und", {31'd0, rasUnderflow}, 32'd0);
    step(3'd5, 0, '0, '0, '0, 0);         expectPc("und_ret", 9'h048);
    chk("und_flag", {31'd0, rasUnderflow}, 32'd1);
    chk("ovf_sticky", {31'd0, rasOverflow}, 32'd1);

    step(3'd0, 1, '0, '0, '0, 0);         expectPc("halt1", 9'h048);
    step(3'd0, 1, '0, '0, '0, 0);         expectPc("halt2", 9'h048);
    step(3'd7, 1, '0, '0, '0, 0);         expectPc("halt_rsv", 9'h048);
    step(3'd1, 1, 9'h040, '0, '0, 0);     expectPc("halt_abs", 9'h040);
    step(3'd1, 0, 9'h1FC, '0, '0, 0);
    step(3'd0, 0, '0, '0, '0, 0);         expectPc("wrap", 9'h000);

`ifdef PC_EXC_EN
    step(3'd1, 0, 9'h030, '0, '0, 0);
    cntBefore = rasCount;
    step(3'd4, 0, 9'h100, '0, '0, 1);     expectPc("exc_pc", 9'h1F0);
    chk("exc_epc", {23'd0, epc}, 32'h030);
    chk("exc_cnt", {29'd0, rasCount}, {29'd0, cntBefore});
`else
    cntBefore = rasCount;
    step(3'd0, 0, '0, '0, '0, 0);
    chk("seq_cnt_hold", {29'd0, rasCount}, {29'd0, cntBefore});
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) doReset();
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) c = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
      h = ($urandom_range(0, 3) == 0);
      if (c == 3'd5 && mStack.size() == 0) h = 1'b0;
`ifdef PC_EXC_EN
      x = ($urandom_range(0, 15) == 0);
`else
      x = 1'b0;
`endif
      step(c, h, 9'($urandom), 9'($urandom), 9'($urandom), x);
    end

    started = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised next-generation program counter for the cpu, with a hardware return-address stack (RAS) for call/return.
- Selects the next fetch address from these sources:
  - sequential increment
  - absolute branch
  - PC-relative branch
  - jump-register
  - call (push return address)
  - return (pop return address)
- Sits between the control decoder/regfile and instruction memory; pc drives the instruction-memory address.

Parameters:
- ADDR_W, 9, width of pc and all address inputs.
- INC, 4, bytes per instruction added on sequential advance.
- RAS_DEPTH, 4, number of return-address entries (power of 2, >=2).
- RESET_ADDR, 0, pc value after reset.

Ports:
- clk  input  1  clock; all state updates on the falling edge (negedge clk).
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- halt  input  1  hold pc when no redirect is requested.
- branchCtl  input  3  next-pc select (encodings under Behaviour).
- nextAdrx  input  ADDR_W  absolute branch/call target.
- offset  input  ADDR_W  signed two's-complement byte offset for relative branch.
- rfRdData0  input  ADDR_W  jump-register target from regfile.
- pc  output  ADDR_W  current program count.
- rasCount  output  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- rasOverflow  output  1  sticky: a push occurred while the RAS was full.
- rasUnderflow  output  1  sticky: a pop occurred while the RAS was empty.

Behaviour:
- Reset (rst=0, asynchronous, immediate) sets:
  - pc=RESET_ADDR
  - rasCount=0
  - RAS pointer=0
  - rasOverflow=0, rasUnderflow=0
  - RAS entry contents are don't-care.
- Reset deassertion takes effect at the next falling edge; reset mid-call discards all stack state.
- branchCtl encodings, evaluated at each negedge clk:
  - 000 SEQ: pc <= pc+INC.
  - 001 BR_ABS: pc <= nextAdrx.
  - 010 BR_REL: pc <= pc + offset.
  - 011 JR: pc <= rfRdData0.
  - 100 CALL: push pc+INC onto the RAS; pc <= nextAdrx.
  - 101 RET: pop the top of the RAS into pc.
  - 110, 111 reserved: behave as SEQ.
- Priority: reset > redirect (001–101) > halt > SEQ.
  - halt=1 with branchCtl=000 (or reserved): pc and RAS unchanged.
  - halt=1 with a redirect: the redirect still executes (branches resolve through halt).
- Arithmetic:
  - All pc arithmetic is modulo 2^ADDR_W; wrap-around is silent (e.g. pc=max-3, INC=4 gives pc+INC-2^ADDR_W).
  - offset is added unextended at full ADDR_W width, so negative offsets wrap correctly.
- RAS organisation: circular buffer with a top pointer; push writes to the next slot, pop reads the top slot.
- Push when full (rasCount==RAS_DEPTH):
  - oldest entry is overwritten
  - pointer advances, rasCount stays at RAS_DEPTH
  - rasOverflow <= 1 (sticky until reset).
- Pop when empty (rasCount==0):
  - pc <= pc+INC (treated as SEQ)
  - pointer and rasCount unchanged
  - rasUnderflow <= 1 (sticky).
- Latency: single cycle. The new pc is visible immediately after the falling edge that samples the control. A CALL followed by a RET on the next edge returns the just-pushed address.
- No simultaneous push and pop is possible (one encoding per cycle).

Optional Feature:
- Macro: PC_EXC_EN.
- When defined, adds ports and parameter:
  - input exc (1)
  - output epc (ADDR_W)
  - parameter EXC_VECTOR (default 9'h1F0).
- exc=1 at a negedge has priority over every branchCtl value and halt:
  - epc <= pc (address of the interrupted instruction)
  - pc <= EXC_VECTOR
  - RAS unchanged.
- epc resets to 0.
- When undefined: no exc/epc ports, no EXC_VECTOR logic; behaviour exactly as above.

Test Plan:
- Reset then 3 SEQ edges (halt=0) -> pc 0x000, 0x004, 0x008, 0x00C. Assert rst=0 mid-clock -> pc=0x000 immediately, before any clock edge.
- pc=0x010, BR_ABS nextAdrx=0x080 -> 0x080. BR_REL offset=9'h1F8 (-8) -> 0x078. JR rfRdData0=0x100 -> 0x100.
- Calls and returns in LIFO order:
  - at pc=0x020 CALL 0x100, then at 0x100 CALL 0x200 -> rasCount=2
  - RET -> pc=0x104, rasCount=1
  - RET -> pc=0x024, rasCount=0.
- 5 CALLs with RAS_DEPTH=4 (from pcs A..E) -> rasOverflow=1, rasCount=4. Then 4 RETs return E+4, D+4, C+4, B+4. A 5th RET -> pc=prev+4, rasUnderflow=1.
- halt=1 with SEQ for 3 edges -> pc constant. halt=1 with BR_ABS 0x040 -> pc=0x040. pc=0x1FC with SEQ -> 0x000 (wrap).
- With PC_EXC_EN: pc=0x030, exc=1 together with CALL -> pc=0x1F0, epc=0x030, rasCount unchanged.
